// File: rtl/melody_seq.sv
// Melody sequencer: steps through a 16-entry song ROM and emits tone codes for a
// downstream square-wave generator, with a short silent gap closing every note.
module melody_seq #(
  parameter int TICKS_PER_BEAT = 250000,
  parameter int GAP_TICKS      = 10000,
  parameter int LOOP           = 0
) (
  input  logic       clk1M,
  input  logic       rst,
  input  logic       play,
  input  logic       stop,
  output logic [4:0] signal,
  output logic       busy,
  output logic       done,
  output logic [3:0] idx,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NOTE  = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] FETCH = 2'd3;

  localparam logic [4:0]  SILENCE  = 5'b11111;
  localparam logic [20:0] BEAT_LEN = 21'(TICKS_PER_BEAT);
  localparam logic [20:0] GAP_LEN  = 21'(GAP_TICKS);
  localparam bit          HAS_GAP  = (GAP_TICKS != 0);

  // Each entry is {code[4:0], beats[2:0]}; beats == 0 marks end of song.
  function automatic logic [7:0] rom_entry(input logic [3:0] a);
    logic [7:0] e;
    case (a)
      4'd0:    e = {5'b00000, 3'd1};
      4'd1:    e = {5'b00000, 3'd1};
      4'd2:    e = {5'b00100, 3'd1};
      4'd3:    e = {5'b00100, 3'd1};
      4'd4:    e = {5'b00101, 3'd1};
      4'd5:    e = {5'b00101, 3'd1};
      4'd6:    e = {5'b00100, 3'd2};
      4'd7:    e = {5'b00011, 3'd1};
      4'd8:    e = {5'b00011, 3'd1};
      4'd9:    e = {5'b00010, 3'd1};
      4'd10:   e = {5'b00010, 3'd1};
      4'd11:   e = {5'b00001, 3'd1};
      4'd12:   e = {5'b00001, 3'd1};
      4'd13:   e = {5'b00000, 3'd2};
      default: e = {SILENCE, 3'd0};
    endcase
    return e;
  endfunction

  // Codes the tone generator cannot play are muted rather than passed through.
  function automatic logic [4:0] tone(input logic [4:0] code);
    if (code[4:3] == 2'b11 || code[2:0] == 3'b111) return SILENCE;
    return code;
  endfunction

  localparam logic [7:0] FIRST_ENTRY = rom_entry(4'd0);
  localparam logic [4:0] FIRST_CODE  = FIRST_ENTRY[7:3];

  logic [1:0]  state;
  logic [20:0] cnt;
  logic        wrapped;
  logic [7:0]  cur_entry;
  logic [2:0]  cur_beats;
  logic [20:0] note_len;
  logic        note_end;
  logic        gap_end;
  logic        fetch_next;

  always_comb begin
    cur_entry  = rom_entry(idx);
    cur_beats  = cur_entry[2:0];
    note_len   = 21'(cur_beats) * BEAT_LEN - GAP_LEN;
    note_end   = (cnt == note_len - 21'd1);
    gap_end    = (cnt == GAP_LEN - 21'd1);
    fetch_next = (cur_beats != 3'd0) && !wrapped;
  end

  assign dbg_state = state;

  always_ff @(posedge clk1M or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      signal  <= SILENCE;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        // Abort wins over everything, including a simultaneous play.
        state   <= IDLE;
        cnt     <= '0;
        idx     <= '0;
        signal  <= SILENCE;
        busy    <= 1'b0;
        wrapped <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (play) begin
              state   <= NOTE;
              cnt     <= '0;
              idx     <= '0;
              wrapped <= 1'b0;
              signal  <= tone(FIRST_CODE);
              busy    <= 1'b1;
            end
          end
          NOTE: begin
            if (note_end) begin
              cnt    <= '0;
              signal <= SILENCE;
              if (HAS_GAP) begin
                state <= GAP;
              end else begin
                state   <= FETCH;
                idx     <= idx + 4'd1;
                wrapped <= (idx == 4'd15);
              end
            end else begin
              cnt <= cnt + 21'd1;
            end
          end
          GAP: begin
            if (gap_end) begin
              state   <= FETCH;
              cnt     <= '0;
              idx     <= idx + 4'd1;
              wrapped <= (idx == 4'd15);
            end else begin
              cnt <= cnt + 21'd1;
            end
          end
          FETCH: begin
            // idx already points at the new entry; decide where the song goes.
            cnt <= '0;
            if (fetch_next) begin
              state  <= NOTE;
              signal <= tone(cur_entry[7:3]);
            end else if (LOOP != 0) begin
              state   <= NOTE;
              idx     <= '0;
              wrapped <= 1'b0;
              signal  <= tone(FIRST_CODE);
            end else begin
              state   <= IDLE;
              idx     <= '0;
              wrapped <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            signal  <= SILENCE;
            busy    <= 1'b0;
            wrapped <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/melody_seq.md
MELODY_SEQ -- requirements
Module: melody_seq

Interface
REQ-001 The block SHALL have parameter TICKS_PER_BEAT, default 250000, meaning clk1M cycles per beat (0.25 s at 1 MHz).
REQ-002 The block SHALL have parameter GAP_TICKS, default 10000, meaning silent cycles closing each note; the legal range is 0 <= GAP_TICKS < TICKS_PER_BEAT.
REQ-003 The block SHALL have parameter LOOP, default 0, meaning 1 = restart the song at its end and 0 = stop at its end.
REQ-004 The block SHALL have port clk1M, input, 1 bit: the single clock, 1 MHz.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port play, input, 1 bit: start request, sampled on the rising edge of clk1M.
REQ-007 The block SHALL have port stop, input, 1 bit: abort request, sampled on the rising edge of clk1M.
REQ-008 The block SHALL have port signal, output, 5 bits: the tone code for the downstream square-wave generator.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a song is playing.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse at natural song end.
REQ-011 The block SHALL have port idx, output, 4 bits: the current song-ROM index.

Function
REQ-012 Tone code encoding SHALL be as follows: bits[4:3] select the octave (00 middle, 01 low, 10 high); bits[2:0] select the note (0..6 = C D E F G A B); 5'b11111 means silence.
REQ-013 The internal 16-entry song ROM SHALL hold {code[4:0], beats[2:0]} per entry, with beats=0 marking end-of-song.
REQ-014 ROM contents SHALL be as follows: entries 0..13 are C C G G A A G F F E E D D C (middle octave); beats are 2 for entries 6 and 13 and 1 elsewhere; entries 14..15 are {11111, 0}.
REQ-015 The block SHALL have states IDLE, NOTE, GAP and FETCH, with registered outputs only.
REQ-016 In IDLE, the block SHALL drive signal=11111 and busy=0.
REQ-017 A play in IDLE SHALL cause the next cycle to be NOTE with idx=0, signal=ROM[0].code and busy=1.
REQ-018 NOTE SHALL last beats*TICKS_PER_BEAT-GAP_TICKS cycles and then go to GAP, or go directly to FETCH when GAP_TICKS=0.
REQ-019 GAP SHALL drive signal=11111 for GAP_TICKS cycles and then go to FETCH.
REQ-020 FETCH SHALL last one cycle with signal=11111; it SHALL increment idx, wrapping 15->0.
REQ-021 After FETCH, if the new entry has beats!=0 the block SHALL enter NOTE with signal=code.
REQ-022 If the new entry has beats=0 or idx has wrapped, and LOOP=1, the block SHALL set idx=0 and enter NOTE with ROM[0].
REQ-023 If the new entry has beats=0 or idx has wrapped, and LOOP=0, the block SHALL go to IDLE and assert done for exactly that one cycle.
REQ-024 Each beat SHALL therefore occupy exactly TICKS_PER_BEAT cycles including the gap; the FETCH cycle is additive, one cycle per note.
REQ-025 An invalid ROM code (bits[2:0]=111 other than 11111, or bits[4:3]=11) SHALL be output as 11111.
REQ-026 The duration counter SHALL be 21 bits, sufficient for 7*250000.
REQ-027 The duration counter SHALL reset to 0 on every state entry.
REQ-028 A stop in any state SHALL make the next cycle IDLE, with signal=11111, busy=0, idx=0 and no done pulse.
REQ-029 When play and stop are asserted in the same cycle, stop SHALL win.
REQ-030 A play while busy=1 SHALL be ignored and SHALL NOT restart the song.
REQ-031 A play held high SHALL restart the song on the cycle after done.
REQ-032 The signal output SHALL change only at state transitions, with no glitches.

Reset
REQ-033 Asserting rst SHALL immediately force IDLE, signal=11111, busy=0, done=0, idx=0 and counter=0, regardless of the clock.
REQ-034 After rst deasserts, the block SHALL remain in IDLE until play.
REQ-035 A reset asserted mid-note SHALL silence the output without waiting for a clock edge.

Verification
All scenarios use TICKS_PER_BEAT=4 and GAP_TICKS=1 unless noted otherwise.
REQ-036 Scenario (basic start): play pulse at cycle 0 -> cycles 1-3 signal=00000, cycle 4 signal=11111 (GAP), cycle 5 signal=11111 (FETCH) with idx=1, cycles 6-8 signal=00000.
REQ-037 Scenario (2-beat note): at entry 6, G SHALL be held for 7 cycles, followed by 1 gap cycle and 1 FETCH cycle.
REQ-038 Scenario (full song, LOOP=0): done SHALL pulse once, 78 cycles after the play edge (14 notes, 64 note/gap cycles plus 14 FETCH cycles); busy SHALL then fall, signal=11111 and idx=0.
REQ-039 Scenario (abort): stop during entry 3 NOTE -> next cycle is IDLE with signal=11111 and no done pulse; a following play restarts at idx=0.
REQ-040 Scenario (conflicts): simultaneous play and stop in IDLE -> the block stays IDLE; play at entry 5 while busy -> idx sequence unchanged.
REQ-041 Scenario (reset and loop): rst asserted asynchronously mid-GAP -> outputs reach reset values before the next edge; with LOOP=1, entry 13 is followed by FETCH, then entry 0 NOTE, and done never asserts.
